// File: rtl/x3_serial_adder_ctrl_if.sv
`default_nettype none
// =============================================================================
// x3_serial_adder_ctrl_if : operand/result handshake bundle for the serial
//                           XS-3 adder controller.          Revision 1.0
// =============================================================================
interface x3_serial_adder_ctrl_if #(
  parameter int NDIG = 4
);
  logic              in_valid;
  logic              in_ready;
  logic [4*NDIG-1:0] a;
  logic [4*NDIG-1:0] b;
  logic              cin;
  logic              out_valid;
  logic              out_ready;
  logic [4*NDIG-1:0] sum;
  logic              cout;
  logic              busy;
  logic              err;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy, err
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy, err
  );
endinterface
`default_nettype wire

// File: rtl/x3_serial_adder_ctrl.sv
`default_nettype none
// =============================================================================
// x3_serial_adder_ctrl : digit-serial XS-3 adder, one digit per clock, LSD first.
// Optional invalid-code checker: X3_INVALID_CHECK_EN.       Revision 1.0
// =============================================================================
module x3_serial_adder_ctrl #(
  parameter int NDIG = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  x3_serial_adder_ctrl_if.slave bus
);
  localparam int W  = 4 * NDIG;
  localparam int CW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [W-1:0]  a_sr;
  logic [W-1:0]  b_sr;
  logic [W-1:0]  sum_sr;
  logic [W+3:0]  sum_shift;
  logic          carry;
  logic          cout_r;
  logic [CW-1:0] cnt;
  logic [4:0]    s_raw;
  logic [3:0]    digit;
  logic          accept;

  assign accept = bus.in_valid && (state == IDLE);

  // XS-3 digit correction: +3 after a decimal carry, -3 (i.e. +13 mod 16) otherwise
  assign s_raw     = {1'b0, a_sr[3:0]} + {1'b0, b_sr[3:0]} + {4'b0000, carry};
  assign digit     = s_raw[4] ? (s_raw[3:0] + 4'd3) : (s_raw[3:0] + 4'd13);
  assign sum_shift = {digit, sum_sr};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (cnt == LAST) state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      sum_sr <= '0;
      carry  <= 1'b0;
      cout_r <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sr  <= bus.a;
      b_sr  <= bus.b;
      carry <= bus.cin;
      cnt   <= '0;
    end else if (state == RUN) begin
      a_sr   <= a_sr >> 4;
      b_sr   <= b_sr >> 4;
      sum_sr <= sum_shift[W+3:4];
      carry  <= s_raw[4];
      cout_r <= s_raw[4];
      cnt    <= cnt + CW'(1);
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN);
  assign bus.sum       = sum_sr;
  assign bus.cout      = cout_r;

`ifdef X3_INVALID_CHECK_EN
  logic err_r;

  function automatic logic bad_code(input logic [3:0] n);
    return (n <= 4'd2) || (n >= 4'd13);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_r <= 1'b0;
    else if (accept)
      err_r <= 1'b0;
    else if ((state == RUN) && (bad_code(a_sr[3:0]) || bad_code(b_sr[3:0])))
      err_r <= 1'b1;
  end

  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif
endmodule
`default_nettype wire
